// File: rtl/load_store_unit.sv
// Load/store unit: turns a MEM-stage access into one registered data-bus
// request, formats load data and flags misaligned accesses.
//
//   state | meaning
//   IDLE  | no access outstanding; a legal mem_valid access is captured here
//   BUSY  | bus request held stable until dbus_ready is sampled
//   DONE  | single completion cycle; the finishing instruction's mem_valid is ignored
module load_store_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic        MemWriteM,
   input  logic [2:0]  funct3M,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [31:0] dbus_wdata,
   output logic [3:0]  dbus_be,
   input  logic        dbus_ready,
   input  logic [31:0] dbus_rdata,
   output logic [31:0] load_data,
   output logic        stallM,
   output logic        misaligned
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_req;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic [31:0] r_load_data;
   logic        r_misaligned;
   logic [2:0]  r_funct3;
   logic [1:0]  r_off;

   logic        w_legal;
   logic        w_start;
   logic        w_fault;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_fmt;

   always_comb begin
      w_legal = 1'b0;
      case (funct3M)
         3'b000, 3'b100: w_legal = 1'b1;
         3'b001, 3'b101: w_legal = ~ALUResultM[0];
         3'b010:         w_legal = (ALUResultM[1:0] == 2'b00);
         default:        w_legal = 1'b0;
      endcase
   end

   assign w_start = (r_state == S_IDLE) && mem_valid && w_legal;
   assign w_fault = (r_state == S_IDLE) && mem_valid && !w_legal;

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = WriteDataM;
      case (funct3M[1:0])
         2'b00: begin
            w_be    = 4'b0001 << ALUResultM[1:0];
            w_wdata = {4{WriteDataM[7:0]}};
         end
         2'b01: begin
            w_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{WriteDataM[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = WriteDataM;
         end
      endcase
   end

   // Lane select uses the offset captured with the request, not the live address.
   assign w_byte = dbus_rdata[{r_off, 3'b000} +: 8];
   assign w_half = dbus_rdata[{r_off[1], 4'b0000} +: 16];

   always_comb begin
      w_load_fmt = dbus_rdata;
      case (r_funct3)
         3'b000:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_load_fmt = {24'h000000, w_byte};
         3'b001:  w_load_fmt = {{16{w_half[15]}}, w_half};
         3'b101:  w_load_fmt = {16'h0000, w_half};
         default: w_load_fmt = dbus_rdata;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_next = S_BUSY;
         S_BUSY:  if (dbus_ready) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_req        <= 1'b0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_be         <= '0;
         r_load_data  <= '0;
         r_misaligned <= 1'b0;
         r_funct3     <= '0;
         r_off        <= '0;
      end else begin
         r_misaligned <= w_fault;
         if (w_start) begin
            r_req    <= 1'b1;
            r_we     <= MemWriteM;
            r_addr   <= {ALUResultM[31:2], 2'b00};
            r_wdata  <= w_wdata;
            r_be     <= w_be;
            r_funct3 <= funct3M;
            r_off    <= ALUResultM[1:0];
         end else if (w_fault) begin
            r_load_data <= '0;
         end
         if ((r_state == S_BUSY) && dbus_ready) begin
            r_req <= 1'b0;
            if (!r_we) r_load_data <= w_load_fmt;
         end
      end
   end

   assign stallM     = !reset && (w_start || (r_state == S_BUSY));
   assign dbus_req   = r_req;
   assign dbus_we    = r_we;
   assign dbus_addr  = r_addr;
   assign dbus_wdata = r_wdata;
   assign dbus_be    = r_be;
   assign load_data  = r_load_data;
   assign misaligned = r_misaligned;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected bus requests and load results
// are queued as each access is issued and popped when the access completes.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_valid;
   logic        MemWriteM;
   logic [2:0]  funct3M;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic        dbus_req;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [31:0] dbus_wdata;
   logic [3:0]  dbus_be;
   logic        dbus_ready;
   logic [31:0] dbus_rdata;
   logic [31:0] load_data;
   logic        stallM;
   logic        misaligned;

   load_store_unit dut (
      .clk(clk), .reset(reset), .mem_valid(mem_valid), .MemWriteM(MemWriteM),
      .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
      .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .dbus_ready(dbus_ready),
      .dbus_rdata(dbus_rdata), .load_data(load_data), .stallM(stallM),
      .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] ld;
      logic [7:0]  stall;
   } exp_t;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        stable;
      logic [7:0]  stall;
      logic        done_req;
      logic        done_stall;
      logic [31:0] ld;
   } obs_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] cur_ld;

   task automatic expect_access(input logic we, input logic [31:0] addr, wdata,
                                input logic [3:0] be, input logic [31:0] ld, input int delay);
      exp_t e;
      e.req = 1'b1; e.we = we; e.addr = addr; e.wdata = wdata; e.be = be;
      e.ld = ld; e.stall = 8'(delay + 2);
      sb.push_back(e);
   endtask

   // Drives one access and records what the DUT did; bounded by the ready delay.
   task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr, wd, rd,
                             input int delay, output obs_t o);
      o = '0;
      o.stable = 1'b1;
      mem_valid = 1'b1; MemWriteM = we; funct3M = f3; ALUResultM = addr; WriteDataM = wd;
      dbus_ready = 1'b0; dbus_rdata = 32'h0;
      #1 if (stallM) o.stall = o.stall + 8'd1;
      @(posedge clk); #1;
      o.req = dbus_req; o.we = dbus_we; o.addr = dbus_addr; o.wdata = dbus_wdata; o.be = dbus_be;
      for (int i = 0; i <= delay; i++) begin
         if ({dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be} !==
             {o.req, o.we, o.addr, o.wdata, o.be}) o.stable = 1'b0;
         dbus_ready = (i == delay);
         dbus_rdata = (i == delay) ? rd : (32'h5A5A_0000 | 32'(i));
         #1 if (stallM) o.stall = o.stall + 8'd1;
         @(posedge clk); #1;
      end
      dbus_ready = 1'b0;
      o.done_req = dbus_req; o.done_stall = stallM; o.ld = load_data;
      mem_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] rd);
      logic [31:0] sh;
      sh = rd >> (8 * off);
      case (f3)
         3'b000:  ref_load = (sh[7]  ? 32'hFFFF_FF00 : 32'h0) | (sh & 32'hFF);
         3'b100:  ref_load = sh & 32'hFF;
         3'b001:  ref_load = (sh[15] ? 32'hFFFF_0000 : 32'h0) | (sh & 32'hFFFF);
         3'b101:  ref_load = sh & 32'hFFFF;
         default: ref_load = rd;
      endcase
   endfunction

   task automatic check_access(input string name, input obs_t o);
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++; n_err++;
         $display("FAIL %s sb_empty: got no expected entry, want one", name);
         return;
      end
      e = sb.pop_front();
      n_cmp++;
      if ({o.req, o.we, o.addr, o.wdata, o.be} !== {e.req, e.we, e.addr, e.wdata, e.be}) begin
         n_err++;
         $display("FAIL %s bus: got req=%b we=%b addr=%h wdata=%h be=%b want req=%b we=%b addr=%h wdata=%h be=%b",
                  name, o.req, o.we, o.addr, o.wdata, o.be, e.req, e.we, e.addr, e.wdata, e.be);
      end
      n_cmp++;
      if (o.stable !== 1'b1) begin n_err++; $display("FAIL %s stable: got %b want 1", name, o.stable); end
      n_cmp++;
      if (o.stall !== e.stall) begin n_err++; $display("FAIL %s stall_cycles: got %0d want %0d", name, o.stall, e.stall); end
      n_cmp++;
      if ({o.done_req, o.done_stall} !== 2'b00) begin
         n_err++; $display("FAIL %s done_req_stall: got %b%b want 00", name, o.done_req, o.done_stall);
      end
      n_cmp++;
      if (o.ld !== e.ld) begin n_err++; $display("FAIL %s load_data: got %h want %h", name, o.ld, e.ld); end
   endtask

   task automatic test_reset();
      reset = 1'b1; mem_valid = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010;
      ALUResultM = 32'h100; WriteDataM = 32'h1234_5678; dbus_ready = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (stallM !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stallM); end
      n_cmp++;
      if ({dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be, load_data, misaligned} !== 103'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h be=%b ld=%h mis=%b want all 0",
                  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be, load_data, misaligned);
      end
      mem_valid = 1'b0; dbus_ready = 1'b0; reset = 1'b0;
      @(posedge clk); #1;
      cur_ld = 32'h0;
   endtask

   task automatic test_lw();
      obs_t o;
      expect_access(1'b0, 32'h100, 32'h0, 4'b1111, 32'hDEAD_BEEF, 0);
      run_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, o);
      check_access("lw_0x100", o);
      cur_ld = 32'hDEAD_BEEF;
   endtask

   task automatic test_lb_lbu();
      obs_t o;
      expect_access(1'b0, 32'h200, 32'h0, 4'b1000, 32'hFFFF_FF80, 1);
      run_access(1'b0, 3'b000, 32'h203, 32'h0, 32'h8011_2233, 1, o);
      check_access("lb_0x203", o);
      expect_access(1'b0, 32'h200, 32'h0, 4'b1000, 32'h0000_0080, 1);
      run_access(1'b0, 3'b100, 32'h203, 32'h0, 32'h8011_2233, 1, o);
      check_access("lbu_0x203", o);
      cur_ld = 32'h0000_0080;
   endtask

   task automatic test_sh_wait();
      obs_t o;
      expect_access(1'b1, 32'h10, 32'hABCD_ABCD, 4'b1100, cur_ld, 3);
      run_access(1'b1, 3'b001, 32'h12, 32'h0000_ABCD, 32'h1111_1111, 3, o);
      check_access("sh_0x12_wait3", o);
   endtask

   task automatic test_lane_sweep();
      obs_t        o;
      logic [2:0]  f3s [4];
      logic [31:0] rd;
      logic [1:0]  off;
      logic [3:0]  be;
      f3s[0] = 3'b000; f3s[1] = 3'b100; f3s[2] = 3'b001; f3s[3] = 3'b101;
      rd = 32'h7F00_80FF;
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 4; j++) begin
            if (f3s[k][0] && j[0]) continue;
            off = 2'(j);
            if (f3s[k][0]) be = off[1] ? 4'b1100 : 4'b0011;
            else           be = 4'b0001 << off;
            expect_access(1'b0, 32'h400, 32'h0, be, ref_load(f3s[k], off, rd), j % 2);
            run_access(1'b0, f3s[k], 32'h400 + 32'(j), 32'h0, rd, j % 2, o);
            check_access($sformatf("load_f3_%b_off%0d", f3s[k], j), o);
            cur_ld = ref_load(f3s[k], off, rd);
         end
      end
   endtask

   task automatic test_idle_quiet();
      mem_valid = 1'b0; dbus_ready = 1'b1; dbus_rdata = 32'hCCCC_CCCC;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if ({stallM, dbus_req, misaligned, load_data} !== {3'b000, cur_ld}) begin
            n_err++;
            $display("FAIL idle_quiet: got stall=%b req=%b mis=%b ld=%h want 0 0 0 %h",
                     stallM, dbus_req, misaligned, load_data, cur_ld);
         end
      end
      dbus_ready = 1'b0;
   endtask

   task automatic test_misaligned();
      logic [2:0]  f3s [3];
      logic [31:0] ads [3];
      logic        wes [3];
      f3s[0] = 3'b010; ads[0] = 32'h102; wes[0] = 1'b0;
      f3s[1] = 3'b001; ads[1] = 32'h13;  wes[1] = 1'b1;
      f3s[2] = 3'b011; ads[2] = 32'h20;  wes[2] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         mem_valid = 1'b1; MemWriteM = wes[k]; funct3M = f3s[k]; ALUResultM = ads[k];
         WriteDataM = 32'hFFFF_FFFF;
         #1;
         n_cmp++;
         if (stallM !== 1'b0) begin n_err++; $display("FAIL mis%0d_stall: got %b want 0", k, stallM); end
         @(posedge clk); #1;
         n_cmp++;
         if ({misaligned, dbus_req, load_data} !== {2'b10, 32'h0}) begin
            n_err++;
            $display("FAIL mis%0d_pulse: got mis=%b req=%b ld=%h want 1 0 00000000",
                     k, misaligned, dbus_req, load_data);
         end
         mem_valid = 1'b0;
         @(posedge clk); #1;
         n_cmp++;
         if ({misaligned, dbus_req} !== 2'b00) begin
            n_err++; $display("FAIL mis%0d_clear: got mis=%b req=%b want 0 0", k, misaligned, dbus_req);
         end
      end
      cur_ld = 32'h0;
   endtask

   task automatic test_back_to_back();
      obs_t o;
      mem_valid = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; ALUResultM = 32'h300;
      WriteDataM = 32'h0; dbus_ready = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (dbus_req !== 1'b1) begin n_err++; $display("FAIL rst_busy_req: got %b want 1", dbus_req); end
      reset = 1'b1; dbus_ready = 1'b1; dbus_rdata = 32'hEEEE_EEEE;
      #1;
      n_cmp++;
      if (stallM !== 1'b0) begin n_err++; $display("FAIL rst_busy_stall: got %b want 0", stallM); end
      @(posedge clk); #1;
      n_cmp++;
      if ({dbus_req, load_data} !== 33'h0) begin
         n_err++; $display("FAIL rst_busy_abandon: got req=%b ld=%h want 0 00000000", dbus_req, load_data);
      end
      reset = 1'b0; dbus_ready = 1'b0; mem_valid = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (dbus_req !== 1'b0) begin n_err++; $display("FAIL rst_busy_idle: got %b want 0", dbus_req); end
      expect_access(1'b0, 32'h600, 32'h0, 4'b1111, 32'h0102_0304, 0);
      run_access(1'b0, 3'b010, 32'h600, 32'h0, 32'h0102_0304, 0, o);
      check_access("b2b_lw", o);
      expect_access(1'b1, 32'h604, 32'hCAFE_F00D, 4'b1111, 32'h0102_0304, 2);
      run_access(1'b1, 3'b010, 32'h604, 32'hCAFE_F00D, 32'h0, 2, o);
      check_access("b2b_sw", o);
      expect_access(1'b1, 32'h600, 32'hA7A7_A7A7, 4'b0010, 32'h0102_0304, 0);
      run_access(1'b1, 3'b000, 32'h601, 32'h1234_56A7, 32'h0, 0, o);
      check_access("b2b_sb", o);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; mem_valid = 1'b0; MemWriteM = 1'b0; funct3M = 3'b000;
      ALUResultM = 32'h0; WriteDataM = 32'h0; dbus_ready = 1'b0; dbus_rdata = 32'h0;
      cur_ld = 32'h0;
      test_reset();
      test_lw();
      test_lb_lbu();
      test_sh_wait();
      test_lane_sweep();
      test_idle_quiet();
      test_misaligned();
      test_back_to_back();
      n_cmp++;
      if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are named clk and reset.
REQ-002 Port: clk  in  1  rising-edge clock for all state.
REQ-003 Port: reset  in  1  synchronous active-high reset.
REQ-004 Port: mem_valid  in  1  MEM-stage instruction is a load or store.
REQ-005 Port: MemWriteM  in  1  1 = store, 0 = load.
REQ-006 Port: funct3M  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-007 Port: ALUResultM  in  32  byte address of the access.
REQ-008 Port: WriteDataM  in  32  store data, right-aligned.
REQ-009 Port: dbus_req  out  1  bus request, registered.
REQ-010 Port: dbus_we  out  1  bus write enable, registered.
REQ-011 Port: dbus_addr  out  32  word-aligned bus address, registered.
REQ-012 Port: dbus_wdata  out  32  lane-replicated store data, registered.
REQ-013 Port: dbus_be  out  4  byte enables, registered.
REQ-014 Port: dbus_ready  in  1  bus completes the request this cycle.
REQ-015 Port: dbus_rdata  in  32  read word, valid when dbus_ready=1.
REQ-016 Port: load_data  out  32  formatted load result, feeds the MEM/WB register.
REQ-017 Port: stallM  out  1  freeze IF, ID, EX/MEM; combinational.
REQ-018 Port: misaligned  out  1  one-cycle error pulse, registered.

Function
REQ-019 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-020 Access is legal only when: funct3M is in {000,100}; or funct3M is in {001,101} with ALUResultM[0]=0; or funct3M=010 with ALUResultM[1:0]=00.
REQ-021 IDLE with mem_valid=1 and legal access SHALL capture the request, go to BUSY, and set dbus_req=1 at the next edge.
REQ-022 On that capture the bus outputs SHALL be set as follows: dbus_we=MemWriteM and dbus_addr={ALUResultM[31:2],2'b00}.
REQ-023 dbus_be SHALL be: byte = 0001<<addr[1:0]; half = 0011 if addr[1]=0, else 1100; word = 1111.
REQ-024 dbus_wdata SHALL be: byte = WriteDataM[7:0] replicated x4; half = WriteDataM[15:0] replicated x2; word = WriteDataM.
REQ-025 In BUSY, all dbus_* outputs SHALL hold stable until dbus_ready=1 is sampled; there is no timeout.
REQ-026 When BUSY samples dbus_ready=1, the block SHALL go to DONE, clear dbus_req at the same edge, and register load_data for loads.
REQ-027 load_data lane selection SHALL be: byte from rdata[8*addr[1:0]+:8]; half from rdata[16*addr[1]+:16].
REQ-028 load_data extension SHALL be: LB/LH sign-extended; LBU/LHU zero-extended; LW unchanged.
REQ-029 Stores SHALL leave load_data unchanged.
REQ-030 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-031 In DONE, mem_valid SHALL be ignored, because it belongs to the completing instruction.
REQ-032 stallM SHALL be 1 when (IDLE and mem_valid and legal) or BUSY, and 0 otherwise, including throughout DONE.
REQ-033 Minimum latency: request in cycle 0, dbus_req high in cycle 1, ready in cycle 1, DONE in cycle 2 (stall-free), i.e. three cycles.
REQ-034 IDLE with mem_valid=1 and illegal access SHALL pulse misaligned for one cycle at the next edge, issue no bus request, assert no stall, and register load_data=0.
REQ-035 dbus_ready sampled while not in BUSY SHALL be ignored.
REQ-036 mem_valid=0 in IDLE SHALL keep all outputs unchanged except stallM=0.

Reset
REQ-037 Synchronous reset SHALL force: state=IDLE; dbus_req=0, dbus_we=0, dbus_addr=0, dbus_wdata=0, dbus_be=0; load_data=0; misaligned=0.
REQ-038 Reset asserted in BUSY or DONE SHALL abandon the access, with dbus_req=0 from the following cycle; stallM SHALL be 0 while reset is high.
REQ-039 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-040 LW to 0x100, dbus_ready on the first BUSY cycle, rdata=0xDEADBEEF -> dbus_addr=0x100, be=1111, stallM high 2 cycles, load_data=0xDEADBEEF in DONE.
REQ-041 LB to 0x203, rdata=0x80112233 -> be=1000, load_data=0xFFFFFF80; same access with LBU -> load_data=0x00000080.
REQ-042 SH to 0x12, WriteDataM=0x0000ABCD, ready delayed 3 cycles -> dbus_we=1, be=1100, wdata=0xABCDABCD, outputs stable through all 3 wait cycles, load_data unchanged.
REQ-043 LW to 0x102 -> misaligned=1 for exactly one cycle, dbus_req stays 0, stallM stays 0, load_data=0.
REQ-044 Reset pulsed in BUSY, then back-to-back LW/SW -> dbus_req=0 the cycle after reset; the next access starts cleanly from IDLE, with DONE separating the two requests.
